serial_cmd_engine: RTL

Parametrised successor to the board's serial command processor. It decodes single-byte opcodes with little-endian arguments from the UART receiver. It drives the trigger configuration registers and the PLL phase-step/clock-switch controls, and streams replies to the UART transmitter. Compared with the previous block it adds:
- a configurable histogram count and width;
- an argument-timeout abort;
- a full configuration readback;
- an error counter.

---
 rtl/cmd_pkg.sv | 44 ++++
 rtl/tx_byte_streamer.sv | 74 +++++++
 rtl/serial_cmd_engine.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_pkg.sv
// rtl/cmd_pkg.sv - opcodes, states, argument counts and reset values for serial_cmd_engine
package cmd_pkg;

  localparam logic [7:0] OP_VERSION  = 8'd0;
  localparam logic [7:0] OP_COINC    = 8'd1;
  localparam logic [7:0] OP_HISTSEL  = 8'd2;
  localparam logic [7:0] OP_ENABLE   = 8'd3;
  localparam logic [7:0] OP_CLKSW    = 8'd4;
  localparam logic [7:0] OP_PHASE0   = 8'd5;
  localparam logic [7:0] OP_SEED     = 8'd6;
  localparam logic [7:0] OP_PRESCALE = 8'd7;
  localparam logic [7:0] OP_ACTCLK   = 8'd8;
  localparam logic [7:0] OP_UPDOWN   = 8'd9;
  localparam logic [7:0] OP_SNAP     = 8'd10;
  localparam logic [7:0] OP_DEAD     = 8'd11;
  localparam logic [7:0] OP_PHASE3   = 8'd12;
  localparam logic [7:0] OP_ROLLING  = 8'd13;
  localparam logic [7:0] OP_READBACK = 8'd14;

  typedef enum logic [2:0] {
    S_IDLE, S_ARGS, S_EXEC, S_PHASE, S_CLKSW, S_SNAP, S_TX, S_TXWAIT
  } state_t;

  localparam logic [7:0]  RST_COINC    = 8'd20;
  localparam logic [7:0]  RST_DEAD     = 8'd50;
  localparam logic [7:0]  RST_HISTSEL  = 8'd0;
  localparam logic        RST_ENABLE   = 1'b0;
  localparam logic        RST_ROLLING  = 1'b1;
  localparam logic [31:0] RST_PRESCALE = 32'hFFFF_FFFF;
  localparam logic [31:0] RST_SEED     = 32'h0;
  localparam logic        RST_UPDOWN   = 1'b1;

  localparam int RB_BYTES = 13;

  // Number of little-endian argument bytes following each opcode.
  function automatic logic [2:0] arg_count(input logic [7:0] op);
    case (op)
      OP_COINC, OP_HISTSEL, OP_DEAD: arg_count = 3'd1;
      OP_SEED, OP_PRESCALE:          arg_count = 3'd4;
      default:                       arg_count = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/tx_byte_streamer.sv
// rtl/tx_byte_streamer.sv - reply buffer and byte-by-byte transmit handshake
module tx_byte_streamer
  import cmd_pkg::*;
#(
  parameter int MAXB = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    go,
  input  logic [$clog2(MAXB):0]   len,
  input  logic [MAXB*8-1:0]       data,
  input  logic                    tx_busy,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  output logic                    done
);

  localparam int IW = $clog2(MAXB);

  state_t            state, state_n;
  logic [MAXB*8-1:0] buffer;
  logic [IW-1:0]     idx;
  logic [IW:0]       last;
  logic              at_last;

  assign at_last = ({1'b0, idx} == last);
  assign tx_data = buffer[{idx, 3'b000} +: 8];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Handshake sequencing: send when the transmitter is free, then one wait cycle.
  always_comb begin
    state_n  = state;
    tx_start = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE:   if (go) state_n = S_TX;
      S_TX: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_n  = S_TXWAIT;
        end
      end
      S_TXWAIT: begin
        if (at_last) begin
          done    = 1'b1;
          state_n = S_IDLE;
        end else begin
          state_n = S_TX;
        end
      end
      default:  state_n = S_IDLE;
    endcase
  end

  // Buffer capture on go and byte index advance after each sent byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx  <= '0;
      last <= '0;
    end else if (state == S_IDLE && go) begin
      buffer <= data;
      last   <= len - 1'b1;
      idx    <= '0;
    end else if (state == S_TXWAIT && !at_last) begin
      idx <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/serial_cmd_engine.sv
// rtl/serial_cmd_engine.sv - serial opcode decoder driving trigger config and PLL controls
module serial_cmd_engine
  import cmd_pkg::*;
#(
  parameter int NHIST      = 8,
  parameter int HISTW      = 32,
  parameter int TIMEOUT    = 1_000_000,
  parameter int SCAN_DIV   = 16,
  parameter int FW_VERSION = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_ready,
  input  logic [7:0]             rx_data,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic [NHIST*HISTW-1:0] histos,
  output logic                   resethist,
  input  logic                   activeclock,
  output logic [7:0]             coincidence_time,
  output logic [7:0]             dead_time,
  output logic [7:0]             histostosend,
  output logic                   enable_outputs,
  output logic                   dorolling,
  output logic [31:0]            prescale,
  output logic [31:0]            seed,
  output logic                   setseed,
  output logic [2:0]             phasecounterselect,
  output logic                   phaseupdown,
  output logic                   phasestep,
  output logic                   scanclk,
  output logic                   clkswitch,
  output logic [7:0]             err_count
);

  localparam int HBYTES = NHIST * HISTW / 8;
  localparam int MAXB   = (HBYTES > RB_BYTES) ? HBYTES : RB_BYTES;
  localparam int LW     = $clog2(MAXB) + 1;
  localparam int DW8    = MAXB * 8;
  localparam int TW     = $clog2(TIMEOUT + 1);
  localparam int DV     = $clog2(SCAN_DIV + 1);
  localparam logic [7:0] FW_BYTE = 8'(FW_VERSION);

  state_t           state, state_n;
  logic [7:0]       opcode;
  logic [31:0]      arg;
  logic [1:0]       arg_idx;
  logic [TW-1:0]    to_cnt;
  logic [DV-1:0]    div_cnt;
  logic [3:0]       tog_cnt;
  logic [2:0]       sw_cnt;
  logic             scanclk_q, phasestep_q;
  logic             go, done, timed_out, div_end;
  logic [LW-1:0]    len;
  logic [DW8-1:0]   sdata;
  logic [RB_BYTES*8-1:0] rb;

  assign timed_out = (to_cnt == TW'(TIMEOUT - 1));
  assign div_end   = (div_cnt == DV'(SCAN_DIV - 1));
  assign rb = {err_count, seed, prescale,
               {4'b0, phaseupdown, dorolling, activeclock, enable_outputs},
               histostosend, dead_time, coincidence_time};

  // PLL controls drop the moment reset is asserted, not one edge later.
  assign scanclk   = scanclk_q & ~reset;
  assign phasestep = phasestep_q & ~reset;
  assign clkswitch = (state == S_CLKSW) & ~reset;

  tx_byte_streamer #(.MAXB(MAXB)) u_streamer (
    .clk      (clk),
    .reset    (reset),
    .go       (go),
    .len      (len),
    .data     (sdata),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .done     (done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next state, reply loading and the histogram clear strobe.
  always_comb begin
    state_n   = state;
    go        = 1'b0;
    len       = '0;
    sdata     = '0;
    resethist = 1'b0;
    case (state)
      S_IDLE: if (rx_ready) state_n = (arg_count(rx_data) != 3'd0) ? S_ARGS : S_EXEC;
      S_ARGS: begin
        if (rx_ready) begin
          if ({1'b0, arg_idx} == arg_count(opcode) - 3'd1) state_n = S_EXEC;
        end else if (timed_out) begin
          state_n = S_IDLE;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_VERSION: begin
            go = 1'b1; len = LW'(1); sdata = DW8'(FW_BYTE); state_n = S_TX;
          end
          OP_ACTCLK: begin
            go = 1'b1; len = LW'(1); sdata = DW8'({7'b0, activeclock}); state_n = S_TX;
          end
          OP_READBACK: begin
            go = 1'b1; len = LW'(RB_BYTES); sdata = DW8'(rb); state_n = S_TX;
          end
          OP_CLKSW:             state_n = S_CLKSW;
          OP_PHASE0, OP_PHASE3: state_n = S_PHASE;
          OP_SNAP:              state_n = S_SNAP;
          default:              state_n = S_IDLE;
        endcase
      end
      S_PHASE: if (div_end && tog_cnt == 4'd7) state_n = S_IDLE;
      S_CLKSW: if (sw_cnt == 3'd7) state_n = S_IDLE;
      S_SNAP: begin
        resethist = 1'b1;
        go        = 1'b1;
        len       = LW'(HBYTES);
        sdata     = DW8'(histos);
        state_n   = S_TX;
      end
      S_TX:    if (done) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Argument collection, register writes, error counting and sequencer counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      opcode             <= '0;
      arg                <= '0;
      arg_idx            <= '0;
      to_cnt             <= '0;
      div_cnt            <= '0;
      tog_cnt            <= '0;
      sw_cnt             <= '0;
      scanclk_q          <= 1'b0;
      phasestep_q        <= 1'b0;
      coincidence_time   <= RST_COINC;
      dead_time          <= RST_DEAD;
      histostosend       <= RST_HISTSEL;
      enable_outputs     <= RST_ENABLE;
      dorolling          <= RST_ROLLING;
      prescale           <= RST_PRESCALE;
      seed               <= RST_SEED;
      setseed            <= 1'b0;
      phasecounterselect <= 3'b000;
      phaseupdown        <= RST_UPDOWN;
      err_count          <= 8'd0;
    end else begin
      setseed <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_ready) begin
            opcode  <= rx_data;
            arg     <= '0;
            arg_idx <= '0;
            to_cnt  <= '0;
          end
        end
        S_ARGS: begin
          if (rx_ready) begin
            arg[{arg_idx, 3'b000} +: 8] <= rx_data;
            arg_idx <= arg_idx + 2'd1;
            to_cnt  <= '0;
          end else if (timed_out) begin
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_EXEC: begin
          case (opcode)
            OP_COINC:    if (arg[7:0] < 8'd64) coincidence_time <= arg[7:0];
            OP_HISTSEL:  histostosend <= arg[7:0];
            OP_ENABLE:   enable_outputs <= ~enable_outputs;
            OP_SEED: begin
              seed    <= arg;
              setseed <= 1'b1;
            end
            OP_PRESCALE: prescale <= arg;
            OP_UPDOWN:   phaseupdown <= ~phaseupdown;
            OP_DEAD:     dead_time <= arg[7:0];
            OP_ROLLING:  dorolling <= ~dorolling;
            OP_CLKSW:    sw_cnt <= '0;
            OP_PHASE0, OP_PHASE3: begin
              phasecounterselect <= (opcode == OP_PHASE0) ? 3'b000 : 3'b011;
              phasestep_q        <= 1'b1;
              scanclk_q          <= 1'b0;
              div_cnt            <= '0;
              tog_cnt            <= '0;
            end
            OP_VERSION, OP_ACTCLK, OP_SNAP, OP_READBACK: ;
            default: if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          endcase
        end
        S_PHASE: begin
          if (div_end) begin
            div_cnt   <= '0;
            scanclk_q <= ~scanclk_q;
            tog_cnt   <= tog_cnt + 4'd1;
            if (tog_cnt == 4'd5) phasestep_q <= 1'b0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_CLKSW: sw_cnt <= sw_cnt + 3'd1;
        default: ;
      endcase
    end
  end

endmodule
